aes_key_expand: RTL and testbench

//  Iterative AES key-schedule engine that sits directly upstream of the aes cipher core.
//  - Accepts a cipher key and computes one 32-bit schedule word w[i] per cycle (FIPS-197 5.2).
//  - Stores the full schedule of Nb*(Nr+1) words.
//  - Serves 128-bit round keys to the cipher/inverse-cipher datapath through a registered read port.

---
 rtl/aes_key_expand_pkg.sv | 73 +++++++
 rtl/aes_key_expand_subword.sv | 14 +
 rtl/aes_key_expand.sv | 172 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expand_pkg.sv
// Shared constants, types and lookup tables for the AES key-schedule engine.
package aes_key_expand_pkg;

  // State columns; fixed for AES.
  localparam int NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ke_state_t;

  // Control registers of the expansion engine.
  //  idx      : index of the schedule word written on the next EXPAND edge
  //  wrap     : idx mod NK, tracked incrementally so no divider is needed
  //  rcon_idx : idx div NK, only meaningful when wrap == 0
  typedef struct packed {
    ke_state_t  state;
    logic [5:0] idx;
    logic [2:0] wrap;
    logic [3:0] rcon_idx;
  } key_exp_reg_t;

  localparam key_exp_reg_t KEY_EXP_REG_INIT = '{
    state:    ST_IDLE,
    idx:      6'd0,
    wrap:     3'd0,
    rcon_idx: 4'd0
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for schedule-word index idx/NK (valid range 1..10).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
// Kept as its own block so the cipher core can reuse it.
module aes_key_expand_subword
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: loads the cipher key, then produces one schedule
// word per cycle into a register array and serves 128-bit round keys through a
// registered read port.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [32*NK-1:0]  key,
  input  logic [3:0]        rk_addr,
  output logic [127:0]      rk_data,
  output logic              keys_valid,
  output logic              done,
  output logic              busy
);

  localparam int NR              = NK + 6;
  localparam int N_WORDS         = NB * (NR + 1);
  localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);
  localparam logic [5:0] FIRST_IDX = 6'(NK);
  localparam logic [2:0] WRAP_MAX = 3'(NK - 1);
  localparam logic [3:0] NR_ADDR  = 4'(NR);

  key_exp_reg_t ctl_reg;
  key_exp_reg_t ctl_next;
  logic         accept;
  logic         keys_valid_reg;
  logic [127:0] rk_data_reg;

  // Sliding window of the last NK schedule words: win_reg[0] = w[i-NK],
  // win_reg[NK-1] = w[i-1]. Keeps the word datapath independent of the
  // schedule array, which then needs only one write and one read port.
  logic [31:0] win_reg [NK];
  logic [31:0] mem [N_WORDS];

  logic [31:0] key_word [NK];
  logic [31:0] last_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] new_word;

  // Key words, word 0 taken from the MSBs.
  for (genvar gi = 0; gi < NK; gi++) begin : g_key_word
    assign key_word[gi] = key[32*(NK-gi)-1 -: 32];
  end

  assign last_word = win_reg[NK-1];
  // RotWord is only applied on the first word of each NK-word group.
  assign sub_in    = (ctl_reg.wrap == 3'd0) ? {last_word[23:0], last_word[31:24]} : last_word;

  aes_key_expand_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Next schedule word w[i] = w[i-NK] ^ f(w[i-1]).
  always_comb begin
    new_word = win_reg[0] ^ last_word;
    if (ctl_reg.wrap == 3'd0) begin
      new_word = win_reg[0] ^ sub_out ^ {rcon(ctl_reg.rcon_idx), 24'h000000};
    end else if (NK == 8 && ctl_reg.wrap == 3'd4) begin
      new_word = win_reg[0] ^ sub_out;
    end
  end

  // FSM next-state logic and status outputs.
  always_comb begin
    ctl_next  = ctl_reg;
    accept    = 1'b0;
    key_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (ctl_reg.state)
      ST_IDLE: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_valid) begin
          accept            = 1'b1;
          ctl_next.state    = ST_EXPAND;
          ctl_next.idx      = FIRST_IDX;
          ctl_next.wrap     = 3'd0;
          ctl_next.rcon_idx = 4'd1;
        end
      end
      ST_EXPAND: begin
        ctl_next.idx = ctl_reg.idx + 6'd1;
        if (ctl_reg.wrap == WRAP_MAX) begin
          ctl_next.wrap     = 3'd0;
          ctl_next.rcon_idx = ctl_reg.rcon_idx + 4'd1;
        end else begin
          ctl_next.wrap = ctl_reg.wrap + 3'd1;
        end
        // Clearing the counters on the final word also keeps rcon_idx <= 10.
        if (ctl_reg.idx == LAST_IDX) begin
          ctl_next = KEY_EXP_REG_INIT;
          ctl_next.state = ST_DONE;
        end
      end
      ST_DONE: begin
        done           = 1'b1;
        ctl_next.state = ST_IDLE;
      end
      default: begin
        ctl_next = KEY_EXP_REG_INIT;
      end
    endcase
  end

  // Control state register and schedule-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_reg        <= KEY_EXP_REG_INIT;
      keys_valid_reg <= 1'b0;
    end else begin
      ctl_reg <= ctl_next;
      if (accept) begin
        keys_valid_reg <= 1'b0;
      end else if (ctl_reg.state == ST_DONE) begin
        keys_valid_reg <= 1'b1;
      end
    end
  end

  // Word window: loaded with the key, then shifts in each new word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK; k++) begin
          win_reg[k] <= key_word[k];
        end
      end else if (ctl_reg.state == ST_EXPAND) begin
        for (int k = 0; k < NK - 1; k++) begin
          win_reg[k] <= win_reg[k+1];
        end
        win_reg[NK-1] <= new_word;
      end
    end
  end

  // Schedule storage: parallel key load, then one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < NK; k++) begin
          mem[k] <= key_word[k];
        end
      end else if (ctl_reg.state == ST_EXPAND) begin
        mem[ctl_reg.idx] <= new_word;
      end
    end
  end

  // Registered round-key read; out-of-range addresses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_data_reg <= 128'h0;
    end else if (rk_addr <= NR_ADDR) begin
      rk_data_reg <= {mem[{rk_addr, 2'b00}], mem[{rk_addr, 2'b01}],
                      mem[{rk_addr, 2'b10}], mem[{rk_addr, 2'b11}]};
    end else begin
      rk_data_reg <= 128'h0;
    end
  end

  assign rk_data    = rk_data_reg;
  assign keys_valid = keys_valid_reg;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one instance each for NK=4/6/8, checked against a
// key-schedule model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;

  logic         clk;
  logic         rst;
  logic         key_valid_a  [3];
  logic [255:0] key_a        [3];
  logic [3:0]   rk_addr_a    [3];
  logic         key_ready_a  [3];
  logic [127:0] rk_data_a    [3];
  logic         keys_valid_a [3];
  logic         done_a       [3];
  logic         busy_a       [3];

  int tests = 0;
  int fails = 0;

  logic [7:0]  sbox_tab [256];
  logic [31:0] ref_w    [64];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int NKI = 4 + 2 * gi;
    aes_key_expand #(.NK(NKI)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid_a[gi]),
      .key_ready  (key_ready_a[gi]),
      .key        (key_a[gi][32*NKI-1:0]),
      .rk_addr    (rk_addr_a[gi]),
      .rk_data    (rk_data_a[gi]),
      .keys_valid (keys_valid_a[gi]),
      .done       (done_a[gi]),
      .busy       (busy_a[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box = affine transform of the multiplicative inverse (x^254).
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int n);
    logic [7:0] rc = 8'h01;
    for (int k = 1; k < n; k++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_tab[t[8*b +: 8]];
    return r;
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    int total = 4 * (nk + 7);
    logic [31:0] t;
    for (int j = 0; j < nk; j++) ref_w[j] = k[32*(nk-1-j) +: 32];
    for (int j = nk; j < total; j++) begin
      t = ref_w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon_ref(j / nk), 24'h000000};
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      ref_w[j] = ref_w[j-nk] ^ t;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic wait_done(input int sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a[sel] && n < 200);
  endtask

  // Present a key to an idle instance and follow it through to IDLE.
  task automatic run_key(input int sel, input logic [255:0] k);
    int nk  = 4 + 2 * sel;
    int lat = 4 * (nk + 7) - nk;
    int n;
    key_a[sel] = k;
    key_valid_a[sel] = 1'b1;
    @(negedge clk);
    key_valid_a[sel] = 1'b0;
    check($sformatf("accept_busy_s%0d", sel), busy_a[sel], 1'b1);
    check($sformatf("accept_kv_clear_s%0d", sel), keys_valid_a[sel], 1'b0);
    wait_done(sel, n);
    check($sformatf("done_latency_s%0d", sel), n, lat);
    @(negedge clk);
    check($sformatf("done_one_cycle_s%0d", sel), done_a[sel], 1'b0);
    check($sformatf("ready_back_s%0d", sel), key_ready_a[sel], 1'b1);
    check($sformatf("keys_valid_set_s%0d", sel), keys_valid_a[sel], 1'b1);
    $display("[TB] expand nk=%0d key=%h done after %0d edges", nk, key_a[sel], n);
  endtask

  task automatic read_rk(input int sel, input int a, output logic [127:0] d);
    rk_addr_a[sel] = 4'(a);
    @(negedge clk);
    d = rk_data_a[sel];
  endtask

  task automatic verify_sched(input int sel, input logic [255:0] k);
    int nk = 4 + 2 * sel;
    int nr = nk + 6;
    logic [127:0] exp;
    logic [127:0] d;
    model_expand(nk, k);
    for (int a = 0; a < 16; a++) begin
      read_rk(sel, a, d);
      if (a <= nr) exp = {ref_w[4*a], ref_w[4*a+1], ref_w[4*a+2], ref_w[4*a+3]};
      else         exp = 128'h0;
      check($sformatf("rk_s%0d_a%0d", sel, a), d, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] ka;
    logic [255:0] kb;
    logic [127:0] d;
    int n;
    int done_cnt;

    for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(8'(x));

    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      key_valid_a[s] = 1'b0;
      key_a[s]       = '0;
      rk_addr_a[s]   = 4'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_ready_s%0d", s), key_ready_a[s], 1'b1);
      check($sformatf("rst_busy_s%0d", s), busy_a[s], 1'b0);
      check($sformatf("rst_done_s%0d", s), done_a[s], 1'b0);
      check($sformatf("rst_kv_s%0d", s), keys_valid_a[s], 1'b0);
      check($sformatf("rst_rk_s%0d", s), rk_data_a[s], 128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors.
    ka = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    run_key(0, ka);
    read_rk(0, 1, d);
    check("kat128_w4", d[127:96], 32'ha0fafe17);
    read_rk(0, 10, d);
    check("kat128_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, 0, d);
    check("kat128_rk0", d, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    verify_sched(0, ka);

    ka = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    run_key(1, ka);
    read_rk(1, 12, d);
    check("kat192_rk12", d, 128'he98ba06f448c773c8ecc720401002202);
    verify_sched(1, ka);

    ka = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    run_key(2, ka);
    read_rk(2, 14, d);
    check("kat256_rk14", d, 128'hfe4890d1e6188d0b046df344706c631e);
    verify_sched(2, ka);

    // Random keys on every key size.
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 2; r++) begin
        ka = rand_key();
        ka = ka & ((256'h1 << (32 * (4 + 2 * s))) - 256'h1);
        run_key(s, ka);
        verify_sched(s, ka);
      end
    end

    // key_valid held with a different key throughout expansion.
    ka = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    kb = rand_key() & ((256'h1 << 128) - 256'h1);
    rk_addr_a[0] = 4'd10;
    key_a[0] = ka;
    key_valid_a[0] = 1'b1;
    @(negedge clk);
    key_a[0] = kb;
    wait_done(0, n);
    check("hold_latency", n, 40);
    check("hold_ready_low_in_done", key_ready_a[0], 1'b0);
    @(negedge clk);
    check("hold_ready_rises", key_ready_a[0], 1'b1);
    check("hold_sched_is_first", rk_data_a[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    key_valid_a[0] = 1'b0;
    check("hold_second_accepted", busy_a[0], 1'b1);
    wait_done(0, n);
    check("hold_second_latency", n, 40);
    @(negedge clk);
    $display("[TB] held-valid second key=%h done after %0d edges", key_a[0], n);
    verify_sched(0, kb);

    // Reset at edge 20 of an expansion.
    key_a[0] = rand_key() & ((256'h1 << 128) - 256'h1);
    key_valid_a[0] = 1'b1;
    @(negedge clk);
    key_valid_a[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", key_ready_a[0], 1'b1);
    check("midrst_busy", busy_a[0], 1'b0);
    check("midrst_kv", keys_valid_a[0], 1'b0);
    check("midrst_done", done_a[0], 1'b0);
    check("midrst_rk", rk_data_a[0], 128'h0);
    check("midrst_kv_other", keys_valid_a[1], 1'b0);
    done_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a[0]) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    $display("[TB] reset mid-expansion, done pulses afterwards=%0d", done_cnt);
    ka = rand_key() & ((256'h1 << 128) - 256'h1);
    run_key(0, ka);
    verify_sched(0, ka);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
